// File: rtl/barrier_pkg.sv
// Shared definitions for the event barrier family: edge-mode encoding and
// the edge-term helper used by every barrier that converts levels to events.
package barrier_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    // Edge term from the synchronised level and its one-cycle history.
    function automatic logic edge_detect(edge_mode_e mode, logic lvl, logic hist);
        logic e;
        e = 1'b0;
        case (mode)
            EDGE_RISE: e = lvl & ~hist;
            EDGE_FALL: e = ~lvl & hist;
            EDGE_BOTH: e = lvl ^ hist;
            default:   e = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// One-bit synchroniser chain plus history flop. All stages advance only
// while enable is high, so an edge that has not yet been consumed stays
// parked between the last stage and the history flop.
module sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic din,
    output logic level,
    output logic hist
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("sync_chain: SYNC_STAGES must be at least 2");
    end

    // s_q[0] samples the asynchronous input; s_q[SYNC_STAGES-1] is the level.
    logic [SYNC_STAGES-1:0] s_q, s_d;
    logic                   h_q, h_d;

    // Next-state: shift the chain and capture history only when enabled.
    always_comb begin
        s_d = s_q;
        h_d = h_q;
        if (enable) begin
            s_d = {s_q[SYNC_STAGES-2:0], din};
            h_d = s_q[SYNC_STAGES-1];
        end
    end

    // Chain and history registers with synchronous reset to the idle level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= {SYNC_STAGES{RST_VALUE}};
            h_q <= RST_VALUE;
        end else begin
            s_q <= s_d;
            h_q <= h_d;
        end
    end

    assign level = s_q[SYNC_STAGES-1];
    assign hist  = h_q;

endmodule

// File: rtl/multi_edge_event_barrier.sv
// Multi-channel clock-domain entry barrier: synchronises WIDTH inputs,
// turns the selected edge into a one-cycle pulse, and latches each event
// in a pending flag until acknowledged, flagging events that land on top
// of an unacknowledged one as a sticky overrun.
module multi_edge_event_barrier
    import barrier_pkg::*;
#(
    parameter int         WIDTH       = 1,
    parameter int         SYNC_STAGES = 2,
    parameter edge_mode_e EDGE_MODE   = EDGE_RISE,
    parameter logic       RST_VALUE   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] ack,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] overrun
);

    if (WIDTH < 1) begin : g_bad_width
        $error("multi_edge_event_barrier: WIDTH must be at least 1");
    end
    if (EDGE_MODE != EDGE_RISE && EDGE_MODE != EDGE_FALL && EDGE_MODE != EDGE_BOTH) begin : g_bad_mode
        $error("multi_edge_event_barrier: unsupported EDGE_MODE");
    end

    logic [WIDTH-1:0] hist;
    logic [WIDTH-1:0] edge_v;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] overrun_q, overrun_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_chain #(
            .SYNC_STAGES (SYNC_STAGES),
            .RST_VALUE   (RST_VALUE)
        ) u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .enable (enable),
            .din    (in[i]),
            .level  (level[i]),
            .hist   (hist[i])
        );
    end

    // Edge term per channel, driven only from registered chain state.
    always_comb begin
        edge_v = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_v[i] = edge_detect(EDGE_MODE, level[i], hist[i]);
        end
    end

    // While disabled the edge stays parked in the chain, so it is masked here.
    assign pulse = edge_v & {WIDTH{enable}};

    // Pending/overrun next state: a new event beats an ack, and an ack
    // arriving with a new event retires the old one without flagging overrun.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (pulse[i]) begin
                pending_d[i] = 1'b1;
                if (ack[i]) begin
                    overrun_d[i] = 1'b0;
                end else if (pending_q[i]) begin
                    overrun_d[i] = 1'b1;
                end
            end else if (ack[i]) begin
                pending_d[i] = 1'b0;
                overrun_d[i] = 1'b0;
            end
        end
    end

    // Event flag registers; reset discards any outstanding events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_multi_edge_event_barrier.sv
// Directed bench for multi_edge_event_barrier: a rising-edge instance with a
// 3-stage chain (dut_r) and a both-edge instance with a 2-stage chain (dut_b).
// Inputs are driven on the falling edge; outputs are sampled 1ns later, so
// every check observes the cycle in which its inputs are applied.
module tb_multi_edge_event_barrier;
    import barrier_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] in_r, ack_r, in_b, ack_b;
    logic [3:0] level_r, pulse_r, pending_r, overrun_r;
    logic [3:0] level_b, pulse_b, pending_b, overrun_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] in;
        logic [3:0] ack;
        logic [3:0] lvl;
        logic [3:0] pul;
        logic [3:0] pnd;
        logic [3:0] ovr;
    } vec_t;

    vec_t vecs[13];
    int   cnt_b[4];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    multi_edge_event_barrier #(
        .WIDTH(4), .SYNC_STAGES(3), .EDGE_MODE(EDGE_RISE), .RST_VALUE(1'b0)
    ) dut_r (
        .clk(clk), .rst_n(rst_n), .enable(en), .in(in_r), .ack(ack_r),
        .level(level_r), .pulse(pulse_r), .pending(pending_r), .overrun(overrun_r)
    );

    multi_edge_event_barrier #(
        .WIDTH(4), .SYNC_STAGES(2), .EDGE_MODE(EDGE_BOTH), .RST_VALUE(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en), .in(in_b), .ack(ack_b),
        .level(level_b), .pulse(pulse_b), .pending(pending_b), .overrun(overrun_b)
    );

    // ---------------- driver ----------------
    task automatic apply(input logic rn, input logic e,
                         input logic [3:0] ir, input logic [3:0] ar,
                         input logic [3:0] ib, input logic [3:0] ab);
        @(negedge clk);
        rst_n = rn;
        en    = e;
        in_r  = ir;
        ack_r = ar;
        in_b  = ib;
        ack_b = ab;
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_r_all(input string name, input logic [3:0] lvl, input logic [3:0] pul,
                               input logic [3:0] pnd, input logic [3:0] ovr);
        check({name, " level"},   {28'd0, level_r},   {28'd0, lvl});
        check({name, " pulse"},   {28'd0, pulse_r},   {28'd0, pul});
        check({name, " pending"}, {28'd0, pending_r}, {28'd0, pnd});
        check({name, " overrun"}, {28'd0, overrun_r}, {28'd0, ovr});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // in, ack, expected level, pulse, pending, overrun (channels [3:0])
        vecs[0]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[3]  = '{4'b0011, 4'b0000, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
        vecs[4]  = '{4'b0010, 4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
        vecs[5]  = '{4'b0010, 4'b1000, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
        vecs[6]  = '{4'b0010, 4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
        vecs[7]  = '{4'b0011, 4'b0000, 4'b0010, 4'b0000, 4'b0011, 4'b0000};
        vecs[8]  = '{4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0011, 4'b0000};
        vecs[9]  = '{4'b0011, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
        vecs[10] = '{4'b0011, 4'b0000, 4'b0011, 4'b0001, 4'b0001, 4'b0000};
        vecs[11] = '{4'b0011, 4'b0001, 4'b0011, 4'b0000, 4'b0001, 4'b0001};
        vecs[12] = '{4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000};

        rst_n = 1'b0; en = 1'b1;
        in_r = '0; ack_r = '0; in_b = '0; ack_b = '0;

        // Reset held for three edges, then one released cycle.
        apply(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        apply(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        check_r_all("rst1", 4'h0, 4'h0, 4'h0, 4'h0);
        apply(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        check_r_all("rst2", 4'h0, 4'h0, 4'h0, 4'h0);
        apply(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        check_r_all("rst_rel", 4'h0, 4'h0, 4'h0, 4'h0);
        check("rst_rel b pulse", {28'd0, pulse_b}, 32'd0);
        apply(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        check_r_all("rst_after", 4'h0, 4'h0, 4'h0, 4'h0);

        // Latency, simultaneous events, ack, overrun.
        for (int i = 0; i < 13; i++) begin
            apply(1'b1, 1'b1, vecs[i].in, vecs[i].ack, 4'h0, 4'h0);
            check_r_all($sformatf("v%0d", i), vecs[i].lvl, vecs[i].pul, vecs[i].pnd, vecs[i].ovr);
        end

        // Enable gating: ch2 edge reaches level, then held for 5 disabled cycles.
        apply(1'b1, 1'b1, 4'b0111, 4'h0, 4'h0, 4'h0);
        apply(1'b1, 1'b1, 4'b0111, 4'h0, 4'h0, 4'h0);
        apply(1'b1, 1'b1, 4'b0111, 4'h0, 4'h0, 4'h0);
        check("en pre level", {28'd0, level_r}, 32'h3);
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, 1'b0, 4'b0111, 4'h0, 4'h0, 4'h0);
            check_r_all($sformatf("en_off%0d", k), 4'b0111, 4'h0, 4'h0, 4'h0);
        end
        apply(1'b1, 1'b1, 4'b0111, 4'h0, 4'h0, 4'h0);
        check("en_on pulse", {28'd0, pulse_r}, 32'h4);
        apply(1'b1, 1'b1, 4'b0111, 4'b0100, 4'h0, 4'h0);
        check("en_on2 pulse", {28'd0, pulse_r}, 32'h0);
        check("en_on2 pending", {28'd0, pending_r}, 32'h4);
        apply(1'b1, 1'b1, 4'b0111, 4'h0, 4'h0, 4'h0);
        check("ack2 pending", {28'd0, pending_r}, 32'h0);

        // Ack coincident with a new pulse on ch3: pending stays, no overrun.
        repeat (3) apply(1'b1, 1'b1, 4'b1111, 4'h0, 4'h0, 4'h0);
        apply(1'b1, 1'b1, 4'b1111, 4'h0, 4'h0, 4'h0);
        check("ch3 first pulse", {28'd0, pulse_r}, 32'h8);
        apply(1'b1, 1'b1, 4'b1111, 4'h0, 4'h0, 4'h0);
        check("ch3 first pending", {28'd0, pending_r}, 32'h8);
        repeat (3) apply(1'b1, 1'b1, 4'b0111, 4'h0, 4'h0, 4'h0);
        repeat (3) apply(1'b1, 1'b1, 4'b1111, 4'h0, 4'h0, 4'h0);
        apply(1'b1, 1'b1, 4'b1111, 4'b1000, 4'h0, 4'h0);
        check("coinc pulse", {28'd0, pulse_r}, 32'h8);
        apply(1'b1, 1'b1, 4'b1111, 4'h0, 4'h0, 4'h0);
        check("coinc pending", {28'd0, pending_r}, 32'h8);
        check("coinc overrun", {28'd0, overrun_r}, 32'h0);

        // Reset mid-flight: ch3 pending, ch1 rise inside the chain.
        repeat (4) apply(1'b1, 1'b1, 4'b0000, 4'h0, 4'h0, 4'h0);
        check("pre_rst pending", {28'd0, pending_r}, 32'h8);
        check("pre_rst pulse", {28'd0, pulse_r}, 32'h0);
        apply(1'b1, 1'b1, 4'b0010, 4'h0, 4'h0, 4'h0);
        apply(1'b1, 1'b1, 4'b0010, 4'h0, 4'h0, 4'h0);
        apply(1'b0, 1'b1, 4'b0000, 4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, 1'b1, 4'b0000, 4'h0, 4'h0, 4'h0);
            check_r_all($sformatf("post_rst%0d", k), 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // EDGE_BOTH: ch2 toggled every 4 cycles, four times.
        for (int k = 0; k < 4; k++) cnt_b[k] = 0;
        in_b = 4'h0;
        for (int c = 0; c < 22; c++) begin
            logic [3:0] nb;
            nb = in_b;
            if (c % 4 == 0 && c < 16) nb[2] = ~nb[2];
            apply(1'b1, 1'b1, 4'h0, 4'h0, nb, 4'h0);
            for (int k = 0; k < 4; k++) cnt_b[k] += int'(pulse_b[k]);
        end
        check("both ch2 pulses", cnt_b[2], 32'd4);
        check("both ch0 pulses", cnt_b[0], 32'd0);
        check("both ch1 pulses", cnt_b[1], 32'd0);
        check("both ch3 pulses", cnt_b[3], 32'd0);
        check("both pending", {28'd0, pending_b}, 32'h4);
        check("both overrun", {28'd0, overrun_b}, 32'h4);
        apply(1'b1, 1'b1, 4'h0, 4'h0, in_b, 4'b0100);
        apply(1'b1, 1'b1, 4'h0, 4'h0, in_b, 4'h0);
        check("both ack pending", {28'd0, pending_b}, 32'h0);
        check("both ack overrun", {28'd0, overrun_b}, 32'h0);

        // EDGE_BOTH: ch1 toggled every 2 cycles, back-to-back pulses.
        for (int k = 0; k < 4; k++) cnt_b[k] = 0;
        for (int c = 0; c < 14; c++) begin
            logic [3:0] nb;
            nb = in_b;
            if (c % 2 == 0 && c < 8) nb[1] = ~nb[1];
            apply(1'b1, 1'b1, 4'h0, 4'h0, nb, 4'h0);
            for (int k = 0; k < 4; k++) cnt_b[k] += int'(pulse_b[k]);
        end
        check("fast ch1 pulses", cnt_b[1], 32'd4);
        check("fast ch2 pulses", cnt_b[2], 32'd0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_edge_event_barrier.md
# multi_edge_event_barrier

Parametrised, multi-channel successor to the single-bit toggle-to-pulse barrier. Synchronises WIDTH asynchronous inputs into the `clk` domain through a configurable-depth synchroniser chain. Converts selected edges into single-cycle pulses and records each event in a per-channel pending/ack flag with sticky overrun detection. Sits at every clock-domain entry point where a consumer must not miss events arriving while it is busy.

## Interface
- `WIDTH`, 1: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2); elaboration error below 2.
- `EDGE_MODE`, EDGE_RISE: EDGE_RISE, EDGE_FALL or EDGE_BOTH; any other value is an elaboration error.
- `RST_VALUE`, 0: value loaded into every synchroniser and history flop at reset; set it to the idle level of `in` so no false edge follows reset.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  advance synchroniser/history; when low all chain registers hold.
- `in`  in  WIDTH  asynchronous inputs.
- `ack`  in  WIDTH  per-channel acknowledge; clears `pending`/`overrun`.
- `level`  out  WIDTH  synchronised level (last chain stage).
- `pulse`  out  WIDTH  one-cycle event strobe.
- `pending`  out  WIDTH  event awaiting acknowledge.
- `overrun`  out  WIDTH  sticky: event arrived while already pending.

## Operation
- Per channel: chain s[0..SYNC_STAGES-1] and history flop h; with `enable`=1 each cycle s[0]<=in, s[k]<=s[k-1], h<=s[last]; `level`=s[last].
- Edge term: rise = level & ~h; fall = ~level & h; both = level ^ h; selected by EDGE_MODE.
- `pulse` = edge & `enable`; registered-only path, no combinational path from `in` or `ack`.
- With `enable`=0 chain and h hold, so an undelivered edge persists and fires on the first enabled cycle; no edge lost, none duplicated.
- Pending/overrun per channel, independent of `enable`, priority top-down:
  - pulse=1, pending=1, ack=0: pending stays 1, overrun<=1.
  - pulse=1, ack=1: pending<=1, overrun<=0 (ack consumes old event, new one pending).
  - pulse=1, pending=0: pending<=1.
  - pulse=0, ack=1: pending<=0, overrun<=0.
  - ack while pending=0 and pulse=0: no effect (also clears overrun, already 0).
- Reset (`rst_n`=0 at a clk edge): s, h <= {RST_VALUE}; pending, overrun <= 0. Reset mid-operation discards in-flight edges and pending events; `pulse` is 0 the cycle after reset provided RST_VALUE matches `in`.
- Channels fully independent; simultaneous events on different channels all reported same cycle.

## Timing
- Reset values: `level`=RST_VALUE, `pulse`=0, `pending`=0, `overrun`=0.
- Latency, `enable` held 1: `in` settles before edge E0 → `level` and `pulse` high in cycle after E0+(SYNC_STAGES-1); `pulse` exactly 1 cycle; `pending` high the cycle after `pulse`.
- `ack` effect visible one cycle after sampling.
- Input pulses shorter than one clk period may be missed; inputs must be held ≥2 clk periods (toggle/level signalling).
- EDGE_BOTH: a toggle on `in` yields one `pulse` per transition; back-to-back toggles at ≥1-cycle spacing yield back-to-back pulses.

## Structure
- Package `barrier_pkg`: EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2 constants and the edge-mode typedef; reused by the existing barriers.
- Sub-module `sync_chain` (SYNC_STAGES, RST_VALUE, enable, 1 bit), instantiated WIDTH times via generate; edge/pending/overrun logic in the top.

## Test plan
- Reset: `rst_n`=0 3 cycles, `in`=0, RST_VALUE=0 → all outputs 0 during and one cycle after; no spurious `pulse`.
- Latency, SYNC_STAGES=3, EDGE_RISE: `in[0]` 0→1 before edge 10 → `pulse[0]` high only in cycle after edge 12, `pending[0]` high from cycle after edge 13.
- EDGE_BOTH, WIDTH=4: toggle `in[2]` every 4 cycles ×4 → exactly 4 pulses on channel 2, none on others.
- Enable gating: rising edge reaches `level` while `enable`=0 for 5 cycles → `pulse`=0 throughout, single `pulse` on first cycle `enable`=1.
- Overrun: two rising events, no `ack` → `overrun`=1; then `ack`=1 one cycle → `pending`=0, `overrun`=0 next cycle; `pulse` coincident with `ack` → `pending` stays 1, `overrun`=0.
- Reset mid-flight: `rst_n` low while edge inside chain and `pending`=1 → after release `pending`=0, no `pulse` for that edge.
